// File: rtl/occupancy_pkg.sv
// Shared types and constant helpers for the classroom occupancy controller.
package occupancy_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        COUNT = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    // Repeated subtraction keeps this a pure constant helper; only called on parameters.
    function automatic bcd_pair_t to_bcd(input int value);
        bcd_pair_t r;
        int        rem;
        rem    = value;
        r.tens = '0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 10) begin
                rem    = rem - 10;
                r.tens = r.tens + 4'd1;
            end
        end
        r.ones = rem[3:0];
        return r;
    endfunction

endpackage

// File: rtl/occupancy_ctrl_if.sv
// Board-side signal bundle: raw switch/buttons in, BCD digits and LEDs out.
interface occupancy_ctrl_if;
    import occupancy_pkg::*;

    logic       sw_enable;
    logic       inc_btn;
    logic       dec_btn;
    bcd_digit_t bcd_ones;
    bcd_digit_t bcd_tens;
    logic       display_on;
    logic       led_warn;
    logic       led_full;
    logic       rejected;

    modport master (
        output sw_enable, inc_btn, dec_btn,
        input  bcd_ones, bcd_tens, display_on, led_warn, led_full, rejected
    );

    modport slave (
        input  sw_enable, inc_btn, dec_btn,
        output bcd_ones, bcd_tens, display_on, led_warn, led_full, rejected
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-count debouncer and one-cycle rising-edge pulse
// for a raw asynchronous pushbutton.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic req_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A mismatch must persist for DEBOUNCE_CYCLES cycles; any return to the old level restarts.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign req_o = level_q & ~prev_q;

endmodule

// File: rtl/occupancy_ctrl.sv
// Occupancy sequencer: arbitrates debounced enter/exit requests onto a BCD counter
// and drives the digit/LED outputs. Define OCC_BLINK_EN to blink led_full while full.
module occupancy_ctrl
    import occupancy_pkg::*;
#(
    parameter int CAPACITY        = 20,
    parameter int WARN_LEVEL      = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic             clock,
    input  logic             reset,
    occupancy_ctrl_if.slave  bus
);

    localparam bcd_pair_t CAP_BCD  = to_bcd(CAPACITY);
    localparam bcd_pair_t WARN_BCD = to_bcd(WARN_LEVEL);

    if (CAPACITY < 1 || CAPACITY > 99) begin : g_bad_capacity
        $error("CAPACITY must be within 1..99");
    end
    if (WARN_LEVEL >= CAPACITY) begin : g_bad_warn
        $error("WARN_LEVEL must be below CAPACITY");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end

    function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
        bcd_pair_t r;
        r = v;
        if (v.ones == 4'd9) begin
            r.ones = '0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_pair_t bcd_dec(input bcd_pair_t v);
        bcd_pair_t r;
        r = v;
        if (v.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = v.tens - 4'd1;
        end else begin
            r.ones = v.ones - 4'd1;
        end
        return r;
    endfunction

    logic      sw_meta_q, sw_sync_q;
    logic      inc_req, dec_req;
    state_t    state_q, state_d;
    bcd_pair_t occ_q, occ_d;
    logic      rejected_q, rejected_d;
    logic      display_on;
    logic      full_phase;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clock (clock),
        .reset (reset),
        .btn_i (bus.inc_btn),
        .req_o (inc_req)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
        .clock (clock),
        .reset (reset),
        .btn_i (bus.dec_btn),
        .req_o (dec_req)
    );

    // Switch-off wins over any request; simultaneous inc/dec cancel without a reject.
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        rejected_d = 1'b0;
        unique case (state_q)
            OFF: begin
                occ_d = '0;
                if (sw_sync_q) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!sw_sync_q) begin
                    state_d = OFF;
                    occ_d   = '0;
                end else if (inc_req && !dec_req) begin
                    occ_d = bcd_inc(occ_q);
                    if (occ_d == CAP_BCD) begin
                        state_d = FULL;
                    end
                end else if (dec_req && !inc_req) begin
                    if (occ_q != '0) begin
                        occ_d = bcd_dec(occ_q);
                    end else begin
                        rejected_d = 1'b1;
                    end
                end
            end
            FULL: begin
                if (!sw_sync_q) begin
                    state_d = OFF;
                    occ_d   = '0;
                end else if (inc_req && !dec_req) begin
                    rejected_d = 1'b1;
                end else if (dec_req && !inc_req) begin
                    occ_d   = bcd_dec(occ_q);
                    state_d = COUNT;
                end
            end
            default: begin
                state_d = OFF;
                occ_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta_q  <= 1'b0;
            sw_sync_q  <= 1'b0;
            state_q    <= OFF;
            occ_q      <= '0;
            rejected_q <= 1'b0;
        end else begin
            sw_meta_q  <= bus.sw_enable;
            sw_sync_q  <= sw_meta_q;
            state_q    <= state_d;
            occ_q      <= occ_d;
            rejected_q <= rejected_d;
        end
    end

`ifdef OCC_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    // Phase restarts at 1 on the edge that enters FULL and is parked at 0 elsewhere.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d == FULL) begin
            if (state_q != FULL) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign full_phase = blink_q;
`else
    assign full_phase = 1'b1;
`endif

    assign display_on     = (state_q != OFF);
    assign bus.display_on = display_on;
    assign bus.bcd_ones   = occ_q.ones;
    assign bus.bcd_tens   = occ_q.tens;
    assign bus.led_warn   = display_on && ({occ_q.tens, occ_q.ones} >= {WARN_BCD.tens, WARN_BCD.ones});
    assign bus.led_full   = display_on && (state_q == FULL) && full_phase;
    assign bus.rejected   = rejected_q;

endmodule
